// File: rtl/cpuy_pkg.sv
// Shared definitions for the code-memory responder.
//   AW      - default CPU address width (memory depth is 2**AW words)
//   DW      - default CPU data width
//   state_t - responder FSM states: SERVE (CPU reads), LOAD (loader writes),
//             DONE (one-cycle completion pulse)
package cpuy_pkg;
  localparam int AW = 12;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/code_ram.sv
// Code storage: 2**AW x DW words with one synchronous write port and one
// registered read port. Contents are never reset.
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address, sampled on every rising edge
//   o_rdata - read data, one cycle after i_raddr (old data on same-address write)
module code_ram #(
  parameter int AW = cpuy_pkg::AW,
  parameter int DW = cpuy_pkg::DW
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/code_mem_responder.sv
// Code-memory responder: serves CPU reads from code_ram and, on request,
// accepts a byte stream from a loader that overwrites a contiguous
// (wrapping) address range while the CPU is held.
//   clk, rst   - clock, synchronous active-high reset
//   addr_bus   - CPU read address
//   data_bus   - read data (1-cycle latency), 0 while loading or after reset
//   cpu_hold   - high during LOAD and DONE
//   ld_start   - begin a load (SERVE only), samples ld_base / ld_len
//   ld_base    - first load address
//   ld_len     - byte count minus one
//   ld_valid   - ld_data valid; ld_ready high in LOAD
//   ld_data    - byte to write
//   ld_abort   - cancel an active load
//   load_done  - one-cycle pulse on completion
//   load_err   - one-cycle pulse on abort
module code_mem_responder #(
  parameter int AW = cpuy_pkg::AW,
  parameter int DW = cpuy_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_bus,
  output logic [DW-1:0] data_bus,
  output logic          cpu_hold,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW-1:0] ld_len,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_abort,
  output logic          load_done,
  output logic          load_err
);
  import cpuy_pkg::*;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_cnt;
  logic          r_hold;
  logic          r_ready;
  logic          r_done;
  logic          r_err;
  logic          r_rd_vld;
  logic          w_we;
  logic [DW-1:0] w_rdata;

  // Abort wins over a simultaneous valid byte; reset blocks the write port.
  assign w_we = (r_state == LOAD) && ld_valid && !ld_abort && !rst;

  code_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(r_ptr),
    .i_wdata(ld_data),
    .i_raddr(addr_bus),
    .o_rdata(w_rdata)
  );

  // r_rd_vld marks cycles whose RAM read was launched from an edge that
  // entered or stayed in SERVE; all other cycles present zero on data_bus.
  assign data_bus  = r_rd_vld ? w_rdata : '0;
  assign cpu_hold  = r_hold;
  assign ld_ready  = r_ready;
  assign load_done = r_done;
  assign load_err  = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SERVE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_hold   <= 1'b0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        SERVE: begin
          if (ld_start) begin
            r_ptr    <= ld_base;
            r_cnt    <= ld_len;
            r_state  <= LOAD;
            r_hold   <= 1'b1;
            r_ready  <= 1'b1;
            r_rd_vld <= 1'b0;
          end else begin
            r_rd_vld <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_abort) begin
            r_state  <= SERVE;
            r_hold   <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b1;
            r_rd_vld <= 1'b1;
          end else if (ld_valid) begin
            r_ptr <= r_ptr + AW'(1);
            r_cnt <= r_cnt - AW'(1);
            if (r_cnt == '0) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state  <= SERVE;
          r_hold   <= 1'b0;
          r_rd_vld <= 1'b1;
        end
        default: r_state <= SERVE;
      endcase
    end
  end
endmodule

// File: tb/tb_code_mem_responder.sv
module tb_code_mem_responder;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr_bus;
  logic [DW-1:0] data_bus;
  logic          cpu_hold;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW-1:0] ld_len;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_abort;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  code_mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .cpu_hold(cpu_hold), .ld_start(ld_start), .ld_base(ld_base),
    .ld_len(ld_len), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_abort(ld_abort), .load_done(load_done),
    .load_err(load_err)
  );

  // Reference model: expected memory image plus "has been written" flags.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  logic [AW-1:0] wq[$];
  logic [DW-1:0] dbuf [16];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit hold, input bit ready,
                          input bit done, input bit err, input bit data_zero);
    chk({tag, ".cpu_hold"},  32'(cpu_hold),  32'(hold));
    chk({tag, ".ld_ready"},  32'(ld_ready),  32'(ready));
    chk({tag, ".load_done"}, 32'(load_done), 32'(done));
    chk({tag, ".load_err"},  32'(load_err),  32'(err));
    if (data_zero) chk({tag, ".data_bus"}, 32'(data_bus), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a);
    addr_bus = a;
    tick();
    if (known[a]) chk({tag, ".rd"}, 32'(data_bus), 32'(ref_mem[a]));
  endtask

  // kill_kind: 0 none, 1 abort together with byte kill_at, 2 reset at byte kill_at.
  task automatic do_load(input string tag, input logic [AW-1:0] base, input int len,
                         input int unsigned stall_pct, input int unsigned fixed_stalls,
                         input int kill_at, input int kill_kind, input bit spurious);
    int n;
    int stalls;
    logic [AW-1:0] a;
    n = len + 1;
    addr_bus = base;
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = AW'(len);
    tick();
    ld_start = 1'b0;
    chk_outs({tag, ".start"}, 1, 1, 0, 0, 1);
    for (int i = 0; i < n; i++) begin
      stalls = (i == 1) ? int'(fixed_stalls) : 0;
      while (stalls < 3 && $urandom_range(99) < stall_pct) stalls++;
      for (int s = 0; s < stalls; s++) begin
        ld_valid = 1'b0;
        ld_data  = DW'($urandom);
        tick();
        chk_outs({tag, ".stall"}, 1, 1, 0, 0, 1);
      end
      ld_valid = 1'b1;
      ld_data  = dbuf[i];
      if (spurious && i == 0) begin
        ld_start = 1'b1;
        ld_base  = base ^ AW'('h800);
        ld_len   = '0;
      end
      if (i == kill_at && kill_kind == 1) ld_abort = 1'b1;
      if (i == kill_at && kill_kind == 2) rst = 1'b1;
      tick();
      ld_valid = 1'b0;
      ld_start = 1'b0;
      ld_abort = 1'b0;
      rst      = 1'b0;
      if (i == kill_at && kill_kind != 0) begin
        if (kill_kind == 1) begin
          chk_outs({tag, ".abort"}, 0, 0, 0, 1, 0);
          if (kill_at > 0) chk({tag, ".abort_rd"}, 32'(data_bus), 32'(ref_mem[base]));
        end else begin
          chk_outs({tag, ".rst"}, 0, 0, 0, 0, 1);
        end
        tick();
        chk_outs({tag, ".after_kill"}, 0, 0, 0, 0, 0);
        if (kill_at > 0) chk({tag, ".after_kill_rd"}, 32'(data_bus), 32'(ref_mem[base]));
        return;
      end
      a = base + AW'(i);
      ref_mem[a] = dbuf[i];
      known[a]   = 1'b1;
      wq.push_back(a);
      if (i < n - 1) chk_outs({tag, ".byte"}, 1, 1, 0, 0, 1);
      else           chk_outs({tag, ".done"}, 1, 0, 1, 0, 1);
    end
    tick();
    chk_outs({tag, ".serve"}, 0, 0, 0, 0, 0);
    chk({tag, ".first_rd"}, 32'(data_bus), 32'(ref_mem[base]));
  endtask

  task automatic prefill(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbuf[0] = d;
    do_load(tag, a, 0, 0, 0, -1, 0, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len;
    int kill;
    logic [AW-1:0] base;
    rst = 1'b1; addr_bus = '0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
    ld_valid = 1'b0; ld_data = '0; ld_abort = 1'b0;
    tick(); tick(); tick();
    chk_outs("reset", 0, 0, 0, 0, 1);
    rst = 1'b0;
    tick();
    chk_outs("idle", 0, 0, 0, 0, 0);

    // abort outside LOAD is ignored
    ld_abort = 1'b1;
    tick();
    ld_abort = 1'b0;
    chk_outs("abort_idle", 0, 0, 0, 0, 0);

    // four-byte load, then read back
    dbuf[0] = 8'hA1; dbuf[1] = 8'hB2; dbuf[2] = 8'hC3; dbuf[3] = 8'hD4;
    do_load("load4", 12'h010, 3, 0, 0, -1, 0, 1'b0);
    rd_chk("load4_012", 12'h012);
    chk("load4_C3", 32'(data_bus), 32'hC3);
    rd_chk("load4_010", 12'h010);
    rd_chk("load4_013", 12'h013);

    // address wrap
    dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33; dbuf[3] = 8'h44;
    do_load("wrap", 12'hFFE, 3, 0, 0, -1, 0, 1'b0);
    rd_chk("wrap_FFE", 12'hFFE);
    rd_chk("wrap_FFF", 12'hFFF);
    rd_chk("wrap_000", 12'h000);
    rd_chk("wrap_001", 12'h001);

    // stalls: valid pattern 1,0,0,1
    dbuf[0] = 8'h5A; dbuf[1] = 8'hA5;
    do_load("stall", 12'h100, 1, 0, 2, -1, 0, 1'b0);
    rd_chk("stall_100", 12'h100);
    rd_chk("stall_101", 12'h101);

    // abort together with the third byte
    prefill("pre202", 12'h202, 8'h77);
    dbuf[0] = 8'h01; dbuf[1] = 8'h02; dbuf[2] = 8'h03; dbuf[3] = 8'h04; dbuf[4] = 8'h05;
    do_load("abort", 12'h200, 4, 0, 0, 2, 1, 1'b0);
    rd_chk("abort_200", 12'h200);
    rd_chk("abort_201", 12'h201);
    rd_chk("abort_202", 12'h202);

    // reset in the middle of a load
    prefill("pre302", 12'h302, 8'h66);
    dbuf[0] = 8'hE1; dbuf[1] = 8'hE2; dbuf[2] = 8'hE3; dbuf[3] = 8'hE4; dbuf[4] = 8'hE5;
    do_load("rstmid", 12'h300, 4, 0, 0, 2, 2, 1'b0);
    rd_chk("rstmid_300", 12'h300);
    rd_chk("rstmid_301", 12'h301);
    rd_chk("rstmid_302", 12'h302);
    rd_chk("stall_100_again", 12'h100);

    // ld_start during LOAD with another base is ignored
    prefill("preC00", 12'hC00, 8'h99);
    dbuf[0] = 8'h40; dbuf[1] = 8'h41; dbuf[2] = 8'h42; dbuf[3] = 8'h43;
    do_load("spur", 12'h400, 3, 0, 0, -1, 0, 1'b1);
    rd_chk("spur_400", 12'h400);
    rd_chk("spur_403", 12'h403);
    rd_chk("spur_C00", 12'hC00);

    // randomized loads with stalls and occasional aborts
    for (int r = 0; r < 10; r++) begin
      base = AW'($urandom);
      len  = int'($urandom_range(7));
      for (int k = 0; k < 16; k++) dbuf[k] = DW'($urandom);
      kill = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
      do_load("rand", base, len, 30, 0, kill, (kill >= 0) ? 1 : 0, 1'b0);
    end
    foreach (wq[q]) rd_chk("rand_rb", wq[q]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/code_mem_responder.md
CODE_MEM_RESPONDER -- requirements
Module: code_mem_responder

Interface
REQ-001 Parameter AW, default 12, address width matching the CPU address bus.
REQ-002 Parameter DW, default 8, data width matching the CPU data bus.
REQ-003 Ports, clock and reset first:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- addr_bus  input  AW  CPU fetch/read address.
- data_bus  output  DW  registered read data returned to the CPU.
- cpu_hold  output  1  high while a load is in progress; system ties it into CPU reset.
- ld_start  input  1  one-cycle request to begin a load.
- ld_base  input  AW  first load address, sampled with ld_start.
- ld_len  input  AW  byte count minus one, sampled with ld_start (0 = 1 byte, all-ones = 2^AW bytes).
- ld_valid  input  1  ld_data is valid.
- ld_ready  output  1  responder accepts ld_data this cycle.
- ld_data  input  DW  byte to write.
- ld_abort  input  1  cancels an active load.
- load_done  output  1  one-cycle pulse when a load completes.
- load_err  output  1  one-cycle pulse when a load is aborted.

Function
REQ-004 Storage shall be 2^AW x DW words, synchronous write, synchronous read.
REQ-005 The FSM shall have three states: SERVE, LOAD, DONE.
REQ-006 In SERVE, data_bus shall equal mem[addr_bus] sampled at the previous edge (1-cycle latency); ld_ready=0; cpu_hold=0.
REQ-007 In SERVE, ld_start=1 shall capture ld_base into the write pointer and ld_len into the remaining count, then go to LOAD on the next edge.
REQ-008 In LOAD, cpu_hold=1, ld_ready=1, and data_bus=0x00.
REQ-009 In LOAD, each cycle with ld_valid=1 shall write ld_data to mem[pointer], increment the pointer modulo 2^AW (wrap 0xFFF->0x000), and decrement the count.
REQ-010 When a byte is accepted with count=0, the FSM shall go to DONE.
REQ-011 ld_valid=0 in LOAD shall be a stall: no write and no state change, with no timeout.
REQ-012 DONE shall last exactly one cycle with load_done=1, cpu_hold=1, and ld_ready=0, then return to SERVE.
REQ-013 ld_abort=1 in LOAD shall take priority over ld_valid in the same cycle: no write, load_err pulses for one cycle, and the next state is SERVE; bytes already written are kept.
REQ-014 ld_start in LOAD or DONE shall be ignored; ld_abort outside LOAD shall be ignored.
REQ-015 The first SERVE cycle after DONE or an abort shall return data reflecting all completed writes (no stale read).
REQ-016 load_done and load_err shall never be high in the same cycle.

Reset
REQ-017 rst=1 at a clock edge shall force SERVE: data_bus=0x00, cpu_hold=0, ld_ready=0, load_done=0, load_err=0, pointer=0, count=0.
REQ-018 Reset shall not clear memory contents.
REQ-019 Reset asserted during LOAD shall end the load with no load_done and no load_err pulse.
REQ-020 The memory write port shall be disabled while rst=1.

Structure
REQ-021 A shared package cpuy_pkg shall hold AW, DW and the state enumeration {SERVE, LOAD, DONE}.
REQ-022 Storage shall be a sub-module code_ram (one write port, one read port, registered read).
REQ-023 The FSM, pointer and count shall reside in code_mem_responder.

Verification
REQ-024 The bench shall cover the following directed scenarios:
- Load 4 bytes (ld_base=0x010, ld_len=3, data A1,B2,C3,D4 back-to-back) -> cpu_hold high for 5 cycles, load_done pulses once, then addr 0x012 gives data_bus=C3 one cycle later.
- Wrap: ld_base=0xFFE, ld_len=3, data 11,22,33,44 -> mem[FFE]=11, mem[FFF]=22, mem[000]=33, mem[001]=44.
- Stalls: ld_valid toggles 1,0,0,1 for a 2-byte load -> exactly 2 writes; load_done is 1 cycle after the last accept.
- Abort after 2 of 5 bytes, with ld_abort and ld_valid high together -> load_err=1, the 3rd byte is not written, first two bytes readable, no load_done.
- rst mid-LOAD -> all outputs at reset values next cycle; previously loaded bytes still readable.
- ld_start during LOAD with a different ld_base -> ignored; the original load completes to its original addresses.
